phase_timer_ctrl: RTL and testbench
===================================

PHASE_TIMER_CTRL -- requirements
Module: phase_timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10: clk cycles per one-second tick; legal range 2 and above.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reprogram  input  1  level-sampled write strobe for time parameters.
REQ-005 time_param_selector  input  2  parameter select: 0=tBASE, 1=tEXT, 2=tYEL, 3=reserved.
REQ-006 time_value  input  4  new parameter value in seconds.
REQ-007 start_timer  input  1  one-cycle request to begin an interval.
REQ-008 interval_sel  input  2  interval select: 0=tBASE, 1=tEXT, 2=tYEL, 3=tBASE+tEXT.
REQ-009 expired  output  1  one-cycle pulse at interval end.
REQ-010 busy  output  1  high while an interval is running.
REQ-011 remaining  output  5  seconds left in the current interval; 0 when idle.
REQ-012 restart  output  1  one-cycle pulse; tells the light FSM to return to its start state.
REQ-013 prog_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-014 Parameter registers shall be 4 bits each, with defaults tBASE=6, tEXT=3, tYEL=2.
REQ-015 A write with reprogram=1, selector 0..2 and time_value!=0 shall store time_value in the selected register on that edge.
- restart pulses on the next cycle.
REQ-016 A write with reprogram=1 and either time_value=0 or selector=3 shall leave all registers unchanged.
- prog_err pulses on the next cycle.
- restart still pulses.
REQ-017 While reprogram=1, every edge shall be treated as a new write (no edge detection).
REQ-018 reprogram=1 shall abort any running interval: state to IDLE, remaining=0, divider cleared, no expired pulse.
REQ-019 The timer FSM shall have two states, IDLE and RUN.
REQ-020 In either state, start_timer=1 with reprogram=0 shall:
- load remaining with the selected interval;
- clear the tick divider;
- enter RUN.
REQ-021 A start in RUN shall restart the interval; the old interval produces no expired pulse.
REQ-022 Interval 3 shall be the 5-bit zero-extended sum tBASE+tEXT (maximum 30), with no truncation.
REQ-023 In RUN, the divider shall count 0..TICK_DIV-1; at wrap a tick occurs and remaining decrements.
REQ-024 On the tick that takes remaining from 1 to 0:
- expired is high during the cycle after that edge;
- state returns to IDLE.
REQ-025 Interval latency: a start sampled on edge E shall produce expired high in exactly cycle E + N*TICK_DIV, where N is the loaded value.
REQ-026 busy shall equal (state==RUN).
REQ-027 If start_timer=1 and reprogram=1 on the same edge, reprogram shall win and the start is dropped.
REQ-028 A start in the same cycle that expired is high shall be accepted normally (back-to-back intervals, no gap).
REQ-029 Parameter values shall be sampled only at start; a write during RUN is impossible because it aborts the interval (REQ-018).
REQ-030 expired, restart and prog_err shall be registered outputs.

Reset
REQ-031 While reset=1, asynchronously:
- parameters take their defaults;
- state=IDLE; divider=0; remaining=0;
- expired, busy, restart and prog_err = 0.
REQ-032 Reset asserted mid-interval shall cancel the interval with no expired pulse.
REQ-033 The first start is accepted on the first rising edge after reset deasserts.

Structure
REQ-034 Package phase_timer_pkg shall hold:
- default parameter values;
- selector and interval encodings;
- the IDLE/RUN state type;
- the TICK_DIV default.
REQ-035 One sub-module, tick_divider, shall implement the clear-able modulo-TICK_DIV counter with a tick output.
REQ-036 No other hierarchy; target size is 150-300 lines of RTL.

Verification (TICK_DIV=4)
REQ-037 Reset, then start with interval_sel=0 -> busy=1, remaining=6, expired high exactly 24 cycles after the start edge, then busy=0.
REQ-038 Write selector=1, value 9 -> restart pulse; then start with interval_sel=3 -> remaining=15, expired after 60 cycles.
REQ-039 Write value 0 to selector 2 -> prog_err and restart pulse; start with interval_sel=2 -> remaining=2, expired after 8 cycles.
REQ-040 Start tBASE, assert reprogram at cycle 10 -> busy=0 next cycle, remaining=0, no expired pulse ever.
REQ-041 Start tYEL and re-start with interval_sel=0 on the expired cycle -> second interval runs 24 cycles with no idle gap.
REQ-042 Assert reset at cycle 5 of a tBASE interval -> all outputs 0 immediately; parameters return to 6/3/2.

Source files
------------

// File: rtl/phase_timer_pkg.sv
// Shared constants and types for the phase timer controller.
// Holds parameter defaults, selector/interval encodings and FSM states.
package phase_timer_pkg;

  localparam int TICK_DIV_DEF = 10;

  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;

  // time_param_selector encodings
  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  // interval_sel encodings
  localparam logic [1:0] IV_BASE = 2'd0;
  localparam logic [1:0] IV_EXT  = 2'd1;
  localparam logic [1:0] IV_YEL  = 2'd2;
  localparam logic [1:0] IV_SUM  = 2'd3;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Interval length in seconds; the sum is widened so 15+15 fits.
  function automatic logic [4:0] interval_len(
    input logic [1:0] sel,
    input logic [3:0] t_base,
    input logic [3:0] t_ext,
    input logic [3:0] t_yel
  );
    logic [4:0] len;
    unique case (sel)
      IV_BASE: len = {1'b0, t_base};
      IV_EXT:  len = {1'b0, t_ext};
      IV_YEL:  len = {1'b0, t_yel};
      IV_SUM:  len = {1'b0, t_base} + {1'b0, t_ext};
    endcase
    return len;
  endfunction

endpackage

// File: rtl/phase_timer_ctrl_tick_divider.sv
// Clear-able modulo-TICK_DIV counter producing a one-second tick.
// Ports: clk, reset, clear (sync zero), enable (count), tick (at wrap).
module tick_divider #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = enable && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/phase_timer_ctrl.sv
// Programmable interval timer for a traffic-light phase FSM.
// Ports: clk, reset, reprogram/time_param_selector/time_value (param
// writes), start_timer/interval_sel (interval start), expired, busy,
// remaining, restart, prog_err.
module phase_timer_ctrl
  import phase_timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reprogram,
  input  logic [1:0] time_param_selector,
  input  logic [3:0] time_value,
  input  logic       start_timer,
  input  logic [1:0] interval_sel,
  output logic       expired,
  output logic       busy,
  output logic [4:0] remaining,
  output logic       restart,
  output logic       prog_err
);

  state_t     r_state;
  logic [3:0] r_base;
  logic [3:0] r_ext;
  logic [3:0] r_yel;
  logic [4:0] r_remaining;
  logic       r_expired;
  logic       r_restart;
  logic       r_prog_err;

  logic       w_tick;
  logic       w_run;
  logic       w_bad_wr;
  logic       w_start;
  logic [4:0] w_len;

  assign w_run    = (r_state == ST_RUN);
  assign w_bad_wr = (time_value == 4'd0) ||
                    (time_param_selector == SEL_RSVD);
  // reprogram dominates a simultaneous start
  assign w_start  = start_timer && !reprogram;
  assign w_len    = interval_len(interval_sel, r_base, r_ext, r_yel);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (reprogram || start_timer),
    .enable (w_run),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= T_BASE_DEF;
      r_ext  <= T_EXT_DEF;
      r_yel  <= T_YEL_DEF;
    end else if (reprogram && !w_bad_wr) begin
      unique case (time_param_selector)
        SEL_BASE: r_base <= time_value;
        SEL_EXT:  r_ext  <= time_value;
        SEL_YEL:  r_yel  <= time_value;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= 5'd0;
      r_expired   <= 1'b0;
      r_restart   <= 1'b0;
      r_prog_err  <= 1'b0;
    end else begin
      r_restart  <= reprogram;
      r_prog_err <= reprogram && w_bad_wr;
      r_expired  <= 1'b0;
      if (reprogram) begin
        r_state     <= ST_IDLE;
        r_remaining <= 5'd0;
      end else if (w_start) begin
        r_state     <= ST_RUN;
        r_remaining <= w_len;
      end else if (w_run && w_tick) begin
        r_remaining <= r_remaining - 5'd1;
        if (r_remaining == 5'd1) begin
          r_state   <= ST_IDLE;
          r_expired <= 1'b1;
        end
      end
    end
  end

  assign expired   = r_expired;
  assign busy      = w_run;
  assign remaining = r_remaining;
  assign restart   = r_restart;
  assign prog_err  = r_prog_err;

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Directed bench for phase_timer_ctrl with TICK_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_phase_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_selector = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       start_timer = 1'b0;
  logic [1:0] interval_sel = 2'd0;
  logic       expired;
  logic       busy;
  logic [4:0] remaining;
  logic       restart;
  logic       prog_err;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_timer_ctrl #(.TICK_DIV(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .reprogram           (reprogram),
    .time_param_selector (time_param_selector),
    .time_value          (time_value),
    .start_timer         (start_timer),
    .interval_sel        (interval_sel),
    .expired             (expired),
    .busy                (busy),
    .remaining           (remaining),
    .restart             (restart),
    .prog_err            (prog_err)
  );

  // Leaves the bench at the falling edge right after the start edge.
  task automatic start_iv(input logic [1:0] sel);
    @(negedge clk);
    start_timer  = 1'b1;
    interval_sel = sel;
    @(negedge clk);
    start_timer  = 1'b0;
  endtask

  // Issues the strobe from the current falling edge (no extra wait).
  task automatic write_now(input logic [1:0] sel, input logic [3:0] val);
    reprogram           = 1'b1;
    time_param_selector = sel;
    time_value          = val;
    @(negedge clk);
    reprogram           = 1'b0;
  endtask

  // Cycles from the current falling edge until expired is seen; -1 on timeout.
  task automatic wait_exp(output int k, input int limit);
    k = 0;
    while (!expired && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!expired) k = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({expired, busy, remaining, restart, prog_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outs got %b exp 0",
               {expired, busy, remaining, restart, prog_err});
    end
    reset = 1'b0;
  endtask

  task automatic test_base;
    int k;
    start_iv(2'd0);
    n_tests++;
    if (busy !== 1'b1 || remaining !== 5'd6) begin
      n_fail++;
      $display("FAIL base_load got busy=%b rem=%0d exp 1/6", busy, remaining);
    end
    wait_exp(k, 100);
    n_tests++;
    if (k !== 24) begin
      n_fail++;
      $display("FAIL base_latency got %0d exp 24", k);
    end
    n_tests++;
    if (busy !== 1'b0 || remaining !== 5'd0) begin
      n_fail++;
      $display("FAIL base_idle got busy=%b rem=%0d exp 0/0", busy, remaining);
    end
    @(negedge clk);
    n_tests++;
    if (expired !== 1'b0) begin
      n_fail++;
      $display("FAIL base_pulse_len got %b exp 0", expired);
    end
  endtask

  task automatic test_write_sum;
    int k;
    write_now(2'd1, 4'd9);
    n_tests++;
    if (restart !== 1'b1 || prog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ok got rst=%b err=%b exp 1/0", restart, prog_err);
    end
    @(negedge clk);
    n_tests++;
    if (restart !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_restart_len got %b exp 0", restart);
    end
    start_iv(2'd3);
    n_tests++;
    if (remaining !== 5'd15) begin
      n_fail++;
      $display("FAIL sum_load got %0d exp 15", remaining);
    end
    wait_exp(k, 200);
    n_tests++;
    if (k !== 60) begin
      n_fail++;
      $display("FAIL sum_latency got %0d exp 60", k);
    end
  endtask

  task automatic test_bad_write;
    int k;
    @(negedge clk);
    write_now(2'd2, 4'd0);
    n_tests++;
    if (restart !== 1'b1 || prog_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_zero got rst=%b err=%b exp 1/1", restart, prog_err);
    end
    write_now(2'd3, 4'd5);
    n_tests++;
    if (restart !== 1'b1 || prog_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rsvd got rst=%b err=%b exp 1/1", restart, prog_err);
    end
    start_iv(2'd2);
    n_tests++;
    if (remaining !== 5'd2) begin
      n_fail++;
      $display("FAIL yel_load got %0d exp 2", remaining);
    end
    wait_exp(k, 100);
    n_tests++;
    if (k !== 8) begin
      n_fail++;
      $display("FAIL yel_latency got %0d exp 8", k);
    end
  endtask

  task automatic test_abort;
    int k;
    start_iv(2'd0);
    repeat (9) @(negedge clk);
    write_now(2'd0, 4'd6);
    n_tests++;
    if (busy !== 1'b0 || remaining !== 5'd0) begin
      n_fail++;
      $display("FAIL abort got busy=%b rem=%0d exp 0/0", busy, remaining);
    end
    wait_exp(k, 40);
    n_tests++;
    if (k !== -1) begin
      n_fail++;
      $display("FAIL abort_noexp got %0d exp -1", k);
    end
    // start together with reprogram is dropped
    reprogram    = 1'b1;
    start_timer  = 1'b1;
    interval_sel = 2'd0;
    time_param_selector = 2'd3;
    time_value   = 4'd1;
    @(negedge clk);
    reprogram    = 1'b0;
    start_timer  = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || restart !== 1'b1) begin
      n_fail++;
      $display("FAIL start_vs_wr got busy=%b rst=%b exp 0/1", busy, restart);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    start_iv(2'd2);
    wait_exp(k, 100);
    n_tests++;
    if (k !== 8) begin
      n_fail++;
      $display("FAIL b2b_first got %0d exp 8", k);
    end
    start_timer  = 1'b1;
    interval_sel = 2'd0;
    @(negedge clk);
    start_timer  = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || remaining !== 5'd6) begin
      n_fail++;
      $display("FAIL b2b_load got busy=%b rem=%0d exp 1/6", busy, remaining);
    end
    wait_exp(k, 100);
    n_tests++;
    if (k !== 24) begin
      n_fail++;
      $display("FAIL b2b_second got %0d exp 24", k);
    end
  endtask

  task automatic test_restart_run;
    int k;
    start_iv(2'd2);
    repeat (5) @(negedge clk);
    start_iv(2'd2);
    wait_exp(k, 100);
    n_tests++;
    if (k !== 8) begin
      n_fail++;
      $display("FAIL rerun_latency got %0d exp 8", k);
    end
  endtask

  task automatic test_max_sum;
    @(negedge clk);
    write_now(2'd0, 4'd15);
    write_now(2'd1, 4'd15);
    start_iv(2'd3);
    n_tests++;
    if (remaining !== 5'd30) begin
      n_fail++;
      $display("FAIL max_sum got %0d exp 30", remaining);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    start_iv(2'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({expired, busy, remaining, restart, prog_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_mid got %b exp 0",
               {expired, busy, remaining, restart, prog_err});
    end
    @(negedge clk);
    reset = 1'b0;
    start_timer  = 1'b1;
    interval_sel = 2'd0;
    @(negedge clk);
    start_timer  = 1'b0;
    n_tests++;
    if (remaining !== 5'd6) begin
      n_fail++;
      $display("FAIL rst_base got %0d exp 6", remaining);
    end
    start_iv(2'd1);
    n_tests++;
    if (remaining !== 5'd3) begin
      n_fail++;
      $display("FAIL rst_ext got %0d exp 3", remaining);
    end
    start_iv(2'd2);
    n_tests++;
    if (remaining !== 5'd2) begin
      n_fail++;
      $display("FAIL rst_yel got %0d exp 2", remaining);
    end
    wait_exp(k, 100);
    n_tests++;
    if (k !== 8) begin
      n_fail++;
      $display("FAIL rst_yel_latency got %0d exp 8", k);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_write_sum();
    test_bad_write();
    test_abort();
    test_back_to_back();
    test_restart_run();
    test_max_sum();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
